// File: rtl/mtm_alu_frame_rx.sv
// Serial frame receiver: assembles DATA frames into {B, A}, checks the CMD frame and presents
// operands/opcode or error flags on a ready/valid register. Partial-packet timeout: MTM_RX_TIMEOUT_EN.
module mtm_alu_frame_rx #(
  parameter int unsigned OPERAND_W   = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OPERAND_W-1:0] out_a,
  output logic [OPERAND_W-1:0] out_b,
  output logic [2:0]           out_op,
  output logic [2:0]           out_err,
  output logic                 out_overrun
);

  localparam int unsigned DataW   = 2 * OPERAND_W;
  localparam int unsigned NFrames = DataW / 8;
  localparam int unsigned CntW    = $clog2(NFrames + 1);
  localparam int unsigned MsgW    = DataW + 4;
  localparam logic [CntW-1:0] NFramesC = CntW'(NFrames);

  localparam logic [2:0] ErrData = 3'b100;
  localparam logic [2:0] ErrCrc  = 3'b010;
  localparam logic [2:0] ErrOp   = 3'b001;

  typedef enum logic [1:0] {StIdle, StRx, StEval} state_e;

  state_e              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [8:0]          frame_q, frame_d;
  logic [DataW-1:0]    data_q, data_d;
  logic [CntW-1:0]     count_q, count_d;
  logic [6:0]          cmd_q, cmd_d;

  logic                ld;
  logic [2:0]          ld_err;
  logic [OPERAND_W-1:0] ld_a, ld_b;
  logic [2:0]          ld_op;
  logic                crc_ok;
  logic                timeout_hit;

  // CRC4, polynomial x^4+x+1, init 0, MSB first
  function automatic logic [3:0] crc4(input logic [MsgW-1:0] msg);
    logic [3:0] c;
    logic       fb;
    c = 4'h0;
    for (int i = MsgW - 1; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

  function automatic logic op_ok(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b100, 3'b101: op_ok = 1'b1;
      default:                        op_ok = 1'b0;
    endcase
  endfunction

  assign crc_ok = (crc4({data_q, 1'b1, cmd_q[6:4]}) == cmd_q[3:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      frame_q   <= '0;
      data_q    <= '0;
      count_q   <= '0;
      cmd_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
      data_q    <= data_d;
      count_q   <= count_d;
      cmd_q     <= cmd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    frame_d   = frame_q;
    data_d    = data_q;
    count_d   = count_q;
    cmd_d     = cmd_q;
    ld        = 1'b0;
    ld_err    = 3'b000;
    ld_a      = '0;
    ld_b      = '0;
    ld_op     = 3'b000;
    unique case (state_q)
      StIdle: begin
        if (!sin) begin
          state_d   = StRx;
          bit_cnt_d = 4'd0;
        end else if (timeout_hit) begin
          count_d = '0;
          ld      = 1'b1;
          ld_err  = ErrData;
        end
      end
      StRx: begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q != 4'd9) begin
          frame_d = {frame_q[7:0], sin};
        end else begin
          state_d = StIdle;
          if (!sin) begin
            // Framing error: drop the frame but keep the packet position
            ld     = 1'b1;
            ld_err = ErrData;
          end else if (frame_q[8]) begin
            cmd_d   = frame_q[6:0];
            state_d = StEval;
          end else if (count_q == NFramesC) begin
            count_d = '0;
            ld      = 1'b1;
            ld_err  = ErrData;
          end else begin
            data_d  = {data_q[DataW-9:0], frame_q[7:0]};
            count_d = count_q + CntW'(1);
          end
        end
      end
      StEval: begin
        count_d = '0;
        ld      = 1'b1;
        if (count_q != NFramesC) begin
          ld_err = ErrData;
        end else if (!crc_ok) begin
          ld_err = ErrCrc;
        end else if (!op_ok(cmd_q[6:4])) begin
          ld_err = ErrOp;
        end else begin
          ld_a  = data_q[OPERAND_W-1:0];
          ld_b  = data_q[DataW-1:OPERAND_W];
          ld_op = cmd_q[6:4];
        end
        // A start bit right after the CMD stop bit begins the next packet
        if (!sin) begin
          state_d   = StRx;
          bit_cnt_d = 4'd0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef MTM_RX_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TmoW-1:0] idle_q;
  logic            idle_run;

  assign idle_run    = (state_q == StIdle) && sin && (count_q != '0);
  assign timeout_hit = idle_run && (idle_q == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_q <= '0;
    end else if (idle_run && !timeout_hit) begin
      idle_q <= idle_q + TmoW'(1);
    end else begin
      idle_q <= '0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = ^32'(TIMEOUT_CYC);
  assign timeout_hit = 1'b0;
`endif

  // Output register: a held, unaccepted result wins over a new one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_b       <= '0;
      out_op      <= 3'b000;
      out_err     <= 3'b000;
      out_overrun <= 1'b0;
    end else begin
      out_overrun <= ld && out_valid && !out_ready;
      if (ld && (!out_valid || out_ready)) begin
        out_valid <= 1'b1;
        out_a     <= ld_a;
        out_b     <= ld_b;
        out_op    <= ld_op;
        out_err   <= ld_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_frame_rx.sv
// Self-checking bench for mtm_alu_frame_rx: 32-bit and 16-bit instances against a packet-level
// reference model (CRC by polynomial long division). Timeout test runs when MTM_RX_TIMEOUT_EN is set.
module tb_mtm_alu_frame_rx;

  typedef struct packed {
    logic [2:0]  err;
    logic [2:0]  op;
    logic [31:0] b;
    logic [31:0] a;
  } res_t;

  logic clk = 1'b0;
  logic rst, sin_bus, sel16, out_ready, mon_en;
  logic sin32, sin16;

  logic        out_valid32, out_overrun32;
  logic [31:0] out_a32, out_b32;
  logic [2:0]  out_op32, out_err32;
  logic        out_valid16, out_overrun16;
  logic [15:0] out_a16, out_b16;
  logic [2:0]  out_op16, out_err16;

  logic        cur_valid, cur_overrun;
  logic [31:0] cur_a, cur_b;
  logic [2:0]  cur_op, cur_err;
  res_t        cur_res;

  int n_checks = 0;
  int n_pass   = 0;
  res_t mon_q[$];

  assign sin32 = sel16 ? 1'b1 : sin_bus;
  assign sin16 = sel16 ? sin_bus : 1'b1;

  assign cur_valid   = sel16 ? out_valid16 : out_valid32;
  assign cur_overrun = sel16 ? out_overrun16 : out_overrun32;
  assign cur_a       = sel16 ? {16'h0, out_a16} : out_a32;
  assign cur_b       = sel16 ? {16'h0, out_b16} : out_b32;
  assign cur_op      = sel16 ? out_op16 : out_op32;
  assign cur_err     = sel16 ? out_err16 : out_err32;
  assign cur_res     = {cur_err, cur_op, cur_b, cur_a};

  mtm_alu_frame_rx #(.OPERAND_W(32), .TIMEOUT_CYC(16)) dut32 (
    .clk(clk), .rst(rst), .sin(sin32), .out_ready(out_ready), .out_valid(out_valid32),
    .out_a(out_a32), .out_b(out_b32), .out_op(out_op32), .out_err(out_err32),
    .out_overrun(out_overrun32)
  );

  mtm_alu_frame_rx #(.OPERAND_W(16), .TIMEOUT_CYC(16)) dut16 (
    .clk(clk), .rst(rst), .sin(sin16), .out_ready(out_ready), .out_valid(out_valid16),
    .out_a(out_a16), .out_b(out_b16), .out_op(out_op16), .out_err(out_err16),
    .out_overrun(out_overrun16)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && cur_valid && out_ready) mon_q.push_back(cur_res);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] wmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic logic [3:0] ref_crc(input logic [31:0] a, input logic [31:0] b,
                                         input int w, input logic [2:0] op);
    logic [71:0] r;
    int len;
    len = 2 * w + 4;
    r = ((72'(b & wmask(w)) << (w + 4)) | (72'(a & wmask(w)) << 4) | 72'({1'b1, op})) << 4;
    for (int i = len + 3; i >= 4; i--) begin
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  function automatic logic [6:0] good_cmd(input logic [31:0] a, input logic [31:0] b,
                                          input int w, input logic [2:0] op);
    return {op, ref_crc(a, b, w, op)};
  endfunction

  function automatic res_t ref_result(input int nfr, input int w, input logic [31:0] a,
                                      input logic [31:0] b, input logic [6:0] cmd);
    res_t r;
    r = '0;
    if (nfr != 2 * w / 8) r.err = 3'b100;
    else if (ref_crc(a, b, w, cmd[6:4]) != cmd[3:0]) r.err = 3'b010;
    else if (!(cmd[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101})) r.err = 3'b001;
    else begin
      r.a  = a & wmask(w);
      r.b  = b & wmask(w);
      r.op = cmd[6:4];
    end
    return r;
  endfunction

  function automatic res_t err_data_res();
    res_t r;
    r = '0;
    r.err = 3'b100;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic send_bit(input logic b);
    sin_bus = b;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    send_bit(stop);
    sin_bus = 1'b1;
  endtask

  task automatic send_packet(input logic [31:0] a, input logic [31:0] b, input int w,
                             input logic [6:0] cmd);
    logic [63:0] v;
    v = ({32'h0, b & wmask(w)} << w) | {32'h0, a & wmask(w)};
    for (int i = 2 * w / 8 - 1; i >= 0; i--) send_frame(1'b0, v[8*i +: 8], 1'b1);
    send_frame(1'b1, {1'b0, cmd}, 1'b1);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!cur_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if ({out_valid32, out_a32, out_b32, out_op32, out_err32, out_overrun32} !== 72'h0) begin
      $display("FAIL reset_hold32: got valid=%b a=%h b=%h op=%b err=%b ovr=%b, expected all 0",
               out_valid32, out_a32, out_b32, out_op32, out_err32, out_overrun32);
    end else n_pass++;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({out_valid16, out_a16, out_b16, out_op16, out_err16, out_overrun16} !== 40'h0) begin
      $display("FAIL reset_out16: got valid=%b a=%h b=%h, expected all 0",
               out_valid16, out_a16, out_b16);
    end else n_pass++;
  endtask

  task automatic test_zero_packet();
    res_t exp;
    int cyc;
    exp = ref_result(8, 32, 32'h0, 32'h0, 7'h0B);
    send_packet(32'h0, 32'h0, 32, 7'h0B);
    wait_valid(cyc);
    n_checks++;
    if (cyc != 1) $display("FAIL zero_latency: got %0d cycles, expected 1", cyc);
    else n_pass++;
    n_checks++;
    if (cur_valid !== 1'b1 || cur_res !== exp)
      $display("FAIL zero_result: got valid=%b res=%h, expected 1 %h", cur_valid, cur_res, exp);
    else n_pass++;
    accept();
    n_checks++;
    if (cur_valid !== 1'b0) $display("FAIL zero_accept: got valid=%b, expected 0", cur_valid);
    else n_pass++;
  endtask

  task automatic test_add_overrun();
    res_t exp1, exp2;
    logic [6:0] c1, c2;
    int cyc;
    c1 = good_cmd(32'hFFFF_FFFF, 32'h0, 32, 3'b100);
    exp1 = ref_result(8, 32, 32'hFFFF_FFFF, 32'h0, c1);
    send_packet(32'hFFFF_FFFF, 32'h0, 32, c1);
    wait_valid(cyc);
    n_checks++;
    if (cur_valid !== 1'b1 || cur_res !== exp1)
      $display("FAIL add_result: got valid=%b res=%h, expected 1 %h", cur_valid, cur_res, exp1);
    else n_pass++;
    c2 = good_cmd(32'h1234_5678, 32'h9ABC_DEF0, 32, 3'b101);
    exp2 = ref_result(8, 32, 32'h1234_5678, 32'h9ABC_DEF0, c2);
    send_packet(32'h1234_5678, 32'h9ABC_DEF0, 32, c2);
    n_checks++;
    if (cur_overrun !== 1'b0) $display("FAIL overrun_early: got %b, expected 0", cur_overrun);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cur_overrun !== 1'b1 || cur_valid !== 1'b1 || cur_res !== exp1)
      $display("FAIL overrun_pulse: got ovr=%b valid=%b res=%h, expected 1 1 %h",
               cur_overrun, cur_valid, cur_res, exp1);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cur_overrun !== 1'b0 || cur_res !== exp1)
      $display("FAIL overrun_width: got ovr=%b res=%h, expected 0 %h", cur_overrun, cur_res, exp1);
    else n_pass++;
    accept();
    // Accept and new result on the same edge: the new one loads
    send_packet(32'h1234_5678, 32'h9ABC_DEF0, 32, c2);
    send_packet(32'hFFFF_FFFF, 32'h0, 32, c1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (cur_valid !== 1'b1 || cur_overrun !== 1'b0 || cur_res !== exp1)
      $display("FAIL same_cycle: got valid=%b ovr=%b res=%h, expected 1 0 %h",
               cur_valid, cur_overrun, cur_res, exp1);
    else n_pass++;
    accept();
  endtask

  task automatic test_length();
    res_t exp;
    logic [6:0] c;
    logic [31:0] a, b;
    int cyc;
    mon_q.delete();
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      for (int j = 0; j < k; j++) send_frame(1'b0, 8'hAA, 1'b1);
      send_frame(1'b1, 8'h00, 1'b1);
      repeat (3) @(negedge clk);
      exp = ref_result(k, 32, 32'h0, 32'h0, 7'h00);
      n_checks++;
      if (mon_q.size() != 1 || mon_q[0] !== exp)
        $display("FAIL short_pkt_%0d: got %0d results first=%h, expected 1 %h",
                 k, mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : '0, exp);
      else n_pass++;
      mon_q.delete();
    end
    mon_en = 1'b0;
    out_ready = 1'b0;
    for (int j = 0; j < 8; j++) send_frame(1'b0, 8'hAA, 1'b1);
    n_checks++;
    if (cur_valid !== 1'b0) $display("FAIL ninth_early: got valid=%b, expected 0", cur_valid);
    else n_pass++;
    send_frame(1'b0, 8'hAA, 1'b1);
    n_checks++;
    if (cur_valid !== 1'b1 || cur_res !== err_data_res())
      $display("FAIL ninth_frame: got valid=%b res=%h, expected 1 %h",
               cur_valid, cur_res, err_data_res());
    else n_pass++;
    accept();
    a = $urandom;
    b = $urandom;
    c = good_cmd(a, b, 32, 3'b001);
    exp = ref_result(8, 32, a, b, c);
    send_packet(a, b, 32, c);
    wait_valid(cyc);
    n_checks++;
    if (cur_valid !== 1'b1 || cur_res !== exp)
      $display("FAIL after_ninth: got valid=%b res=%h, expected 1 %h", cur_valid, cur_res, exp);
    else n_pass++;
    accept();
  endtask

  task automatic test_framing();
    logic [31:0] a, b;
    logic [63:0] v;
    logic [6:0] c;
    res_t exp;
    a = $urandom;
    b = $urandom;
    c = good_cmd(a, b, 32, 3'b100);
    exp = ref_result(8, 32, a, b, c);
    v = {b, a};
    mon_q.delete();
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int i = 7; i >= 5; i--) send_frame(1'b0, v[8*i +: 8], 1'b1);
    send_frame(1'b0, 8'h55, 1'b0);
    for (int i = 4; i >= 0; i--) send_frame(1'b0, v[8*i +: 8], 1'b1);
    send_frame(1'b1, {1'b0, c}, 1'b1);
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (mon_q.size() != 2 || mon_q[0] !== err_data_res() || mon_q[1] !== exp)
      $display("FAIL framing: got %0d results, expected %h then %h",
               mon_q.size(), err_data_res(), exp);
    else n_pass++;
  endtask

  task automatic test_crc_op();
    res_t exp;
    logic [6:0] c;
    int cyc;
    c = 7'b000_0000;
    exp = ref_result(8, 32, 32'hAAAA_AAAA, 32'hAAAA_AAAA, c);
    send_packet(32'hAAAA_AAAA, 32'hAAAA_AAAA, 32, c);
    wait_valid(cyc);
    n_checks++;
    if (cur_valid !== 1'b1 || cur_res !== exp)
      $display("FAIL bad_crc: got valid=%b res=%h, expected 1 %h", cur_valid, cur_res, exp);
    else n_pass++;
    accept();
    c = good_cmd(32'hAAAA_AAAA, 32'hAAAA_AAAA, 32, 3'b010);
    exp = ref_result(8, 32, 32'hAAAA_AAAA, 32'hAAAA_AAAA, c);
    send_packet(32'hAAAA_AAAA, 32'hAAAA_AAAA, 32, c);
    wait_valid(cyc);
    n_checks++;
    if (cur_valid !== 1'b1 || cur_res !== exp)
      $display("FAIL bad_op: got valid=%b res=%h, expected 1 %h", cur_valid, cur_res, exp);
    else n_pass++;
    accept();
  endtask

  task automatic test_back_to_back();
    res_t exp_q[$];
    logic [31:0] a, b;
    logic [6:0] c;
    mon_q.delete();
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int p = 0; p < 12; p++) begin
      a = $urandom;
      b = $urandom;
      c = good_cmd(a, b, 32, 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 3) == 0) c[3:0] = c[3:0] ^ 4'($urandom_range(1, 15));
      exp_q.push_back(ref_result(8, 32, a, b, c));
      send_packet(a, b, 32, c);
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (mon_q.size() != exp_q.size())
      $display("FAIL b2b_count: got %0d results, expected %0d", mon_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      n_checks++;
      if (mon_q[i] !== exp_q[i])
        $display("FAIL b2b_result_%0d: got %h, expected %h", i, mon_q[i], exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    logic [6:0] c;
    res_t exp;
    int cyc;
    a = 32'hCAFE_0001;
    b = 32'h0BAD_F00D;
    c = good_cmd(a, b, 32, 3'b000);
    send_packet(a, b, 32, c);
    wait_valid(cyc);
    for (int j = 0; j < 4; j++) send_frame(1'b0, 8'h3C, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out_valid32, out_a32, out_b32, out_op32, out_err32, out_overrun32} !== 72'h0)
      $display("FAIL mid_reset: got valid=%b a=%h b=%h op=%b err=%b, expected all 0",
               out_valid32, out_a32, out_b32, out_op32, out_err32);
    else n_pass++;
    sin_bus = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    a = $urandom;
    b = $urandom;
    c = good_cmd(a, b, 32, 3'b101);
    exp = ref_result(8, 32, a, b, c);
    send_packet(a, b, 32, c);
    wait_valid(cyc);
    n_checks++;
    if (cur_valid !== 1'b1 || cur_res !== exp)
      $display("FAIL after_reset: got valid=%b res=%h, expected 1 %h", cur_valid, cur_res, exp);
    else n_pass++;
    accept();
  endtask

  task automatic test_w16();
    logic [31:0] a, b;
    logic [6:0] c;
    res_t exp;
    int cyc;
    sel16 = 1'b1;
    for (int p = 0; p < 3; p++) begin
      a = (p == 0) ? 32'h0000_BEEF : 32'($urandom_range(0, 65535));
      b = (p == 0) ? 32'h0000_1234 : 32'($urandom_range(0, 65535));
      c = good_cmd(a, b, 16, (p == 2) ? 3'b011 : 3'b100);
      exp = ref_result(4, 16, a, b, c);
      send_packet(a, b, 16, c);
      wait_valid(cyc);
      n_checks++;
      if (cur_valid !== 1'b1 || cur_res !== exp)
        $display("FAIL w16_pkt_%0d: got valid=%b res=%h, expected 1 %h",
                 p, cur_valid, cur_res, exp);
      else n_pass++;
      accept();
    end
    sel16 = 1'b0;
  endtask

`ifdef MTM_RX_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] a, b;
    logic [6:0] c;
    res_t exp;
    int cyc;
    for (int j = 0; j < 3; j++) send_frame(1'b0, 8'h5A, 1'b1);
    repeat (15) @(negedge clk);
    n_checks++;
    if (cur_valid !== 1'b0) $display("FAIL timeout_early: got valid=%b, expected 0", cur_valid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (cur_valid !== 1'b1 || cur_res !== err_data_res())
      $display("FAIL timeout: got valid=%b res=%h, expected 1 %h",
               cur_valid, cur_res, err_data_res());
    else n_pass++;
    accept();
    a = $urandom;
    b = $urandom;
    c = good_cmd(a, b, 32, 3'b001);
    exp = ref_result(8, 32, a, b, c);
    send_packet(a, b, 32, c);
    wait_valid(cyc);
    n_checks++;
    if (cur_valid !== 1'b1 || cur_res !== exp)
      $display("FAIL after_timeout: got valid=%b res=%h, expected 1 %h", cur_valid, cur_res, exp);
    else n_pass++;
    accept();
  endtask
`endif

  initial begin
    rst       = 1'b1;
    sin_bus   = 1'b1;
    sel16     = 1'b0;
    out_ready = 1'b0;
    mon_en    = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_zero_packet();
    test_add_overrun();
    test_length();
    test_framing();
    test_crc_op();
    test_back_to_back();
    test_reset_mid();
    test_w16();
`ifdef MTM_RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
